// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;

    // Pattern that leaves every segment dark for the given segment polarity.
    function automatic logic [SEG_W-1:0] seg_blank(input logic active_low);
        return active_low ? 7'h7F : 7'h00;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_btn_debounce.sv
// Button conditioning: two-flop synchronizer, stable-count debounce and a
// single-cycle pulse on each debounced rising edge.
module btn_debounce #(
    parameter int DEB_CYC = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam int DW = $clog2(DEB_CYC + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic          level_d;
    logic [DW-1:0] count;

    // Bring the raw button into the clock domain before anything looks at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
        end
    end

    // Accept a new level only after it has differed for DEB_CYC cycles in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            count <= '0;
        end else if (sync_b != level) begin
            if (count == DEB_LAST) begin
                level <= sync_b;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end else begin
            count <= '0;
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment driver with per-slot blanking, a
// frame-wide pattern snapshot and a button-toggled decimal/octal selection.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int BLANK_CYC      = 50,
    parameter int DEB_CYC        = 100000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_DIGITS*SEG_W-1:0] dec_digits,
    input  logic [NUM_DIGITS*SEG_W-1:0] oct_digits,
    input  logic                        btn_mode,
    output logic                        nsyst,
    output logic [SEG_W-1:0]            seg_out,
    output logic [NUM_DIGITS-1:0]       an_n,
    output logic                        frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int PW = NUM_DIGITS * SEG_W;
    localparam logic [CW-1:0]    CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]    BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [SEG_W-1:0] BLANK_PAT  = seg_blank(SEG_ACTIVE_LOW != 0);

    scan_state_t            state;
    scan_state_t            state_next;
    logic [1:0]             slot;
    logic [1:0]             slot_next;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_next;
    logic [PW-1:0]          snap;
    logic [PW-1:0]          snap_next;
    logic [SEG_W-1:0]       digit_next;
    logic [NUM_DIGITS-1:0]  an_next;
    logic                   press;

    btn_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_btn_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_mode),
        .rise  (press)
    );

    // Each debounced press flips between decimal and octal display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nsyst <= 1'b1;
        end else if (press) begin
            nsyst <= ~nsyst;
        end
    end

    // Next scan position and the frame snapshot, refreshed only in slot-0 blanking.
    always_comb begin
        state_next = state;
        slot_next  = slot;
        cnt_next   = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            slot_next  = slot + 2'd1;
            state_next = ST_BLANK;
        end else if (state == ST_BLANK && cnt == BLANK_LAST) begin
            state_next = ST_SHOW;
        end

        snap_next = snap;
        if (state == ST_BLANK && slot == 2'd0) begin
            snap_next = nsyst ? dec_digits : oct_digits;
        end
    end

    // Outputs are decoded from the next state so they land on the same edge.
    always_comb begin
        digit_next = snap_next[slot_next*SEG_W +: SEG_W];
        an_next    = '1;
        an_next[slot_next] = 1'b0;
    end

    // Scan state, snapshot and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BLANK;
            slot       <= 2'd0;
            cnt        <= '0;
            snap       <= {NUM_DIGITS{BLANK_PAT}};
            an_n       <= '1;
            seg_out    <= BLANK_PAT;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            slot       <= slot_next;
            cnt        <= cnt_next;
            snap       <= snap_next;
            frame_done <= (slot_next == 2'd3) && (cnt_next == CNT_LAST);
            if (state_next == ST_SHOW) begin
                an_n    <= an_next;
                seg_out <= digit_next;
            end else begin
                an_n    <= '1;
                seg_out <= BLANK_PAT;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a frame-position model predicts every
// output each cycle, with a few hand-computed literal checks along the way.
module tb_seg_scan_ctrl;

    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int DEB_CYC   = 4;
    localparam int FRAME     = 4 * SCAN_DIV;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        btn_mode = 1'b0;
    logic [27:0] dec_digits;
    logic [27:0] oct_digits;
    logic        nsyst;
    logic [6:0]  seg_out;
    logic [3:0]  an_n;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: edges since reset release, frame snapshot, selection, button history.
    int          m_n     = 0;
    logic [27:0] m_snap  = {4{7'h7F}};
    logic        m_nsyst = 1'b1;
    logic        m_s1    = 1'b0;
    logic        m_s2    = 1'b0;
    logic        m_deb   = 1'b0;
    logic        m_pend  = 1'b0;
    int          m_dcnt  = 0;

    logic       e_nsyst = 1'b1;
    logic [6:0] e_seg   = 7'h7F;
    logic [3:0] e_an    = 4'hF;
    logic       e_fd    = 1'b0;

    seg_scan_ctrl #(
        .SCAN_DIV       (SCAN_DIV),
        .BLANK_CYC      (BLANK_CYC),
        .DEB_CYC        (DEB_CYC),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dec_digits (dec_digits),
        .oct_digits (oct_digits),
        .btn_mode   (btn_mode),
        .nsyst      (nsyst),
        .seg_out    (seg_out),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Every frame position maps directly onto slot, blanking and enable pattern.
    function automatic void set_expect();
        int ph;
        int sl;
        int c;
        ph = m_n % FRAME;
        sl = ph / SCAN_DIV;
        c  = ph % SCAN_DIV;
        e_nsyst = m_nsyst;
        e_fd    = (sl == 3) && (c == SCAN_DIV - 1);
        e_an    = 4'hF;
        e_seg   = 7'h7F;
        if (c >= BLANK_CYC) begin
            e_an[sl] = 1'b0;
            e_seg    = m_snap[sl*7 +: 7];
        end
    endfunction

    // Advance the reference one clock, or return it to its reset picture.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n     = 0;
            m_snap  = {4{7'h7F}};
            m_nsyst = 1'b1;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
            m_deb   = 1'b0;
            m_pend  = 1'b0;
            m_dcnt  = 0;
        end else begin
            if ((m_n % FRAME) < BLANK_CYC) begin
                m_snap = m_nsyst ? dec_digits : oct_digits;
            end
            if (m_pend) begin
                m_nsyst = ~m_nsyst;
                m_pend  = 1'b0;
            end
            if (m_s2 != m_deb) begin
                m_dcnt = m_dcnt + 1;
                if (m_dcnt == DEB_CYC) begin
                    m_deb  = m_s2;
                    m_dcnt = 0;
                    if (m_deb) m_pend = 1'b1;
                end
            end else begin
                m_dcnt = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn_mode;
            m_n  = m_n + 1;
        end
        set_expect();
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        check_output("nsyst", {31'd0, nsyst}, {31'd0, e_nsyst});
        check_output("an_n", {28'd0, an_n}, {28'd0, e_an});
        check_output("seg_out", {25'd0, seg_out}, {25'd0, e_seg});
        check_output("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
    end

    task automatic wait_phase(input int p);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if ((m_n % FRAME) == p) return;
        end
        vectors     = vectors + 1;
        miscompares = miscompares + 1;
        $display("[TB] FAIL wait_phase: phase %0d not reached", p);
    endtask

    task automatic apply_stimulus(input int hi, input int lo);
        btn_mode = 1'b1;
        repeat (hi) @(negedge clk);
        btn_mode = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        dec_digits = {7'h30, 7'h24, 7'h79, 7'h40};
        oct_digits = {4{7'h7E}};
        #1 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_output("reset_nsyst", {31'd0, nsyst}, 32'd1);
        check_output("reset_seg", {25'd0, seg_out}, 32'h7F);
        check_output("reset_an", {28'd0, an_n}, 32'hF);
        check_output("reset_fd", {31'd0, frame_done}, 32'd0);
        #2 rst_n = 1'b1;

        @(posedge clk) #1;
        check_output("first_blank_an", {28'd0, an_n}, 32'hF);
        @(posedge clk) #1;
        check_output("slot0_an", {28'd0, an_n}, 32'hE);
        check_output("slot0_seg", {25'd0, seg_out}, 32'h40);
        check_output("model_slot0_an", {28'd0, e_an}, 32'hE);
        repeat (7) @(posedge clk);
        #1;
        check_output("slot1_blank_an", {28'd0, an_n}, 32'hF);
        repeat (29 - 7) @(posedge clk);
        #1;
        check_output("frame_done_hi", {31'd0, frame_done}, 32'd1);
        check_output("slot3_an", {28'd0, an_n}, 32'h7);
        check_output("slot3_seg", {25'd0, seg_out}, 32'h30);
        check_output("model_fd", {31'd0, e_fd}, 32'd1);
        @(posedge clk) #1;
        check_output("frame_done_lo", {31'd0, frame_done}, 32'd0);

        // A press shorter than the debounce window never reaches nsyst.
        @(negedge clk);
        apply_stimulus(3, 12);
        check_output("short_press_nsyst", {31'd0, nsyst}, 32'd1);

        // New patterns mid-frame must not tear the frame already showing.
        wait_phase(10);
        dec_digits = {4{7'h00}};
        wait_phase(18);
        check_output("tear_slot2", {25'd0, seg_out}, 32'h24);
        wait_phase(26);
        check_output("tear_slot3", {25'd0, seg_out}, 32'h30);
        wait_phase(2);
        check_output("tear_next0", {25'd0, seg_out}, 32'h00);
        wait_phase(10);
        check_output("tear_next1", {25'd0, seg_out}, 32'h00);
        dec_digits = {7'h30, 7'h24, 7'h79, 7'h40};

        // Mode press during slot 2: this frame stays decimal, the next shows octal.
        wait_phase(0);
        wait_phase(16);
        btn_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((m_n % FRAME) == 26) begin
                check_output("mode_slot3_seg", {25'd0, seg_out}, 32'h30);
                check_output("mode_nsyst", {31'd0, nsyst}, 32'd0);
            end
            if ((m_n % FRAME) == 2) begin
                check_output("mode_next_seg", {25'd0, seg_out}, 32'h7E);
            end
        end
        btn_mode = 1'b0;
        repeat (12) @(negedge clk);
        check_output("mode_once", {31'd0, nsyst}, 32'd0);

        // Random button bursts around the debounce threshold and random patterns.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) dec_digits = 28'($urandom);
            if ($urandom_range(0, 3) == 0) oct_digits = 28'($urandom);
            apply_stimulus(int'($urandom_range(1, 10)), int'($urandom_range(1, 12)));
        end

        // Reset mid-operation with octal selected.
        repeat (15) @(negedge clk);
        if (m_nsyst) apply_stimulus(10, 12);
        check_output("pre_reset_nsyst", {31'd0, nsyst}, 32'd0);
        wait_phase(18);
        check_output("pre_reset_an", {28'd0, an_n}, 32'hB);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_an", {28'd0, an_n}, 32'hF);
        check_output("async_seg", {25'd0, seg_out}, 32'h7F);
        check_output("async_nsyst", {31'd0, nsyst}, 32'd1);
        check_output("async_fd", {31'd0, frame_done}, 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk) #1;
        check_output("restart_blank", {28'd0, an_n}, 32'hF);
        @(posedge clk) #1;
        check_output("restart_slot0", {28'd0, an_n}, 32'hE);
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
